pixel_stream_tx: RTL and testbench

- Transmit end of the pixel-data path.
- On `start`, fetches one IMG_W×IMG_H greyscale image from the image buffer through a 1-cycle-latency read port.
- Presents the image to the downstream pixel register one byte at a time: `pixel_out` plus a single-cycle `shift_en` strobe, throttled by the consumer's `ready`.
- Sits between the image buffer and the recognizer's pixel-data register; the consumer latches `pixel_out` on every clock edge where `shift_en` is high.

---
 rtl/digit_pkg.sv | 20 ++
 rtl/pixel_coord_counter.sv | 58 +++++
 rtl/pixel_stream_tx.sv | 126 ++++++++++++
 tb/tb_pixel_stream_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// digit_pkg: definitions shared by the pixel-data transmit path.
//   tx_state_t - states of the pixel_stream_tx sequencer
//   IMG_W_DEF  - default image width in pixels
//   IMG_H_DEF  - default image height in rows
//   PIX_W      - width of one greyscale pixel
package digit_pkg;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int PIX_W     = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } tx_state_t;

endpackage

// File: rtl/pixel_coord_counter.sv
// pixel_coord_counter: row/column/linear-address tracker for one image.
// Ports:
//   clk, n_rst - clock, asynchronous active-low reset
//   clr        - return to pixel (0,0), address 0
//   inc        - advance to the next pixel in raster order
//   row, col   - coordinates of the current pixel
//   addr       - linear buffer address, always row*IMG_W + col
//   last       - current pixel is the final one of the image
module pixel_coord_counter
    import digit_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [ADDR_W-1:0]        addr,
    output logic                     last
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);

    logic col_last;

    assign col_last = (col == COL_MAX);
    assign last     = col_last && (row == ROW_MAX);

    // Increment is ignored on the last pixel so the address can never run
    // past the end of the image.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clr) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (inc && !last) begin
            addr <= addr + ADDR_W'(1);
            if (col_last) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: reads one IMG_W x IMG_H greyscale image from the image
// buffer and hands it, one byte per shift_en strobe, to the recognizer's
// pixel register.
// Ports:
//   clk, n_rst  - clock, asynchronous active-low reset
//   start       - begin a frame (only honoured in IDLE)
//   abort       - drop the current frame, back to IDLE without frame_done
//   ready       - consumer can take a pixel this cycle
//   mem_ren     - buffer read enable
//   mem_addr    - buffer read address
//   mem_rdata   - buffer read data, valid the cycle after mem_ren
//   pixel_out   - pixel byte being offered
//   shift_en    - transfer strobe, the consumer latches pixel_out on it
//   row, col    - coordinates of the pixel being offered
//   busy        - high in every state but IDLE
//   frame_done  - one-cycle pulse after the final pixel transfers
module pixel_stream_tx
    import digit_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     ready,
    output logic                     mem_ren,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [PIX_W-1:0]         mem_rdata,
    output logic [PIX_W-1:0]         pixel_out,
    output logic                     shift_en,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic                     busy,
    output logic                     frame_done
);

    tx_state_t state;
    logic      ren_q;
    logic      done_q;
    logic      last;
    logic      cnt_clr;
    logic      cnt_inc;

    // The strobe follows ready within the cycle. The registered read-enable
    // and done pulse are masked by abort so an aborted cycle issues nothing.
    assign shift_en   = (state == PRESENT) && ready && !abort;
    assign mem_ren    = ren_q && !abort;
    assign frame_done = done_q && !abort;

    assign cnt_clr = (state == IDLE) && start && !abort;
    assign cnt_inc = shift_en;

    pixel_coord_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_coord (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .row   (row),
        .col   (col),
        .addr  (mem_addr),
        .last  (last)
    );

    // Registered outputs are set on the transition into the state in which
    // they must be visible.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            pixel_out <= '0;
            ren_q     <= 1'b0;
            done_q    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ren_q  <= 1'b0;
            done_q <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= REQ;
                            ren_q <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    REQ: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        pixel_out <= mem_rdata;
                        state     <= PRESENT;
                    end
                    PRESENT: begin
                        if (ready) begin
                            if (last) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= REQ;
                                ren_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: self-checking bench for pixel_stream_tx. The image
// buffer is an array with a one-cycle read; expected pixels, coordinates and
// addresses come from the raster index (pixel i = buffer[i], row = i / W,
// col = i % W, address = i) and strobe timing from the cycle count since the
// previous transfer.
module tb_pixel_stream_tx;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int ADDR_W = 10;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int LIMIT  = 6000;

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic                     start;
    logic                     abort;
    logic                     ready;
    logic                     mem_ren;
    logic [ADDR_W-1:0]        mem_addr;
    logic [7:0]               mem_rdata = 8'h00;
    logic [7:0]               pixel_out;
    logic                     shift_en;
    logic [$clog2(IMG_H)-1:0] row;
    logic [$clog2(IMG_W)-1:0] col;
    logic                     busy;
    logic                     frame_done;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    pixel_stream_tx #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .ready      (ready),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .pixel_out  (pixel_out),
        .shift_en   (shift_en),
        .row        (row),
        .col        (col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [27:0] exp_strobe(input int idx);
        return {mem[idx], 5'(idx / IMG_W), 5'(idx % IMG_W), 10'(idx)};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({mem_ren, shift_en, busy, frame_done, pixel_out, row, col, mem_addr} !== '0)
            $display("FAIL reset_values got=%h required=0",
                     {mem_ren, shift_en, busy, frame_done, pixel_out, row, col, mem_addr});
        else n_pass++;
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0; #1;
        n_total++;
        if ({busy, mem_ren} !== 2'b00)
            $display("FAIL start_with_abort_idle busy/mem_ren got=%b required=00", {busy, mem_ren});
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int idx = 0, last_s = 0, dones = 0, cyc;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i % 256);
        @(negedge clk); ready = 1'b1; start = 1'b1;
        for (cyc = 1; cyc < LIMIT; cyc++) begin
            @(negedge clk); start = 1'b0; #1;
            if (mem_ren) begin
                n_total++;
                if (int'(mem_addr) >= NPIX)
                    $display("FAIL full_addr_range got=%0d required<%0d", mem_addr, NPIX);
                else n_pass++;
            end
            if (shift_en) begin
                n_total++;
                if ({pixel_out, row, col, mem_addr} !== exp_strobe(idx))
                    $display("FAIL full_strobe[%0d] got=%h required=%h", idx,
                             {pixel_out, row, col, mem_addr}, exp_strobe(idx));
                else n_pass++;
                n_total++;
                if (cyc - last_s !== 3)
                    $display("FAIL full_spacing[%0d] got=%0d required=3", idx, cyc - last_s);
                else n_pass++;
                last_s = cyc; idx++;
            end
            if (frame_done) begin
                dones++;
                n_total++;
                if (cyc - last_s !== 1 || idx !== NPIX)
                    $display("FAIL full_done_timing got=%0d/%0d required=1/%0d", cyc - last_s, idx, NPIX);
                else n_pass++;
            end else if (dones > 0) begin
                n_total++;
                if (busy !== 1'b0) $display("FAIL full_idle_after_done busy got=%b required=0", busy);
                else n_pass++;
                break;
            end
        end
        n_total++;
        if (idx !== NPIX || dones !== 1)
            $display("FAIL full_count strobes/dones got=%0d/%0d required=%0d/1", idx, dones, NPIX);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int idx = 0, dones = 0, s4 = -100, cyc;
        fill_random();
        @(negedge clk); ready = 1'b1; start = 1'b1;
        for (cyc = 1; cyc < LIMIT; cyc++) begin
            @(negedge clk); start = 1'b0;
            ready = !(s4 >= 0 && cyc > s4 && cyc <= s4 + 12); #1;
            if (s4 >= 0 && cyc >= s4 + 3 && cyc <= s4 + 12) begin
                n_total++;
                if ({shift_en, mem_ren, pixel_out} !== {2'b00, mem[5]})
                    $display("FAIL bp_hold se/ren/pix got=%h required=%h",
                             {shift_en, mem_ren, pixel_out}, {2'b00, mem[5]});
                else n_pass++;
            end
            if (shift_en) begin
                n_total++;
                if ({pixel_out, row, col, mem_addr} !== exp_strobe(idx))
                    $display("FAIL bp_strobe[%0d] got=%h required=%h", idx,
                             {pixel_out, row, col, mem_addr}, exp_strobe(idx));
                else n_pass++;
                if (idx == 4) s4 = cyc;
                if (idx == 5) begin
                    n_total++;
                    if (cyc !== s4 + 13) $display("FAIL bp_release_cycle got=%0d required=%0d", cyc, s4 + 13);
                    else n_pass++;
                end
                idx++;
            end
            if (frame_done) dones++;
            else if (dones > 0) break;
        end
        n_total++;
        if (idx !== NPIX || dones !== 1)
            $display("FAIL bp_count strobes/dones got=%0d/%0d required=%0d/1", idx, dones, NPIX);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        int idx = 0, dones = 0, avail = 3, last_s = 0, cyc;
        logic exp_se;
        fill_random();
        @(negedge clk); ready = 1'b1; start = 1'b1;
        for (cyc = 1; cyc < LIMIT; cyc++) begin
            @(negedge clk); start = 1'b0; ready = ($urandom_range(0, 3) != 0); #1;
            exp_se = ready && (cyc >= avail) && (idx < NPIX);
            n_total++;
            if (shift_en !== exp_se)
                $display("FAIL rnd_shift_en cycle %0d got=%b required=%b", cyc, shift_en, exp_se);
            else n_pass++;
            if (shift_en) begin
                n_total++;
                if ({pixel_out, row, col, mem_addr} !== exp_strobe(idx))
                    $display("FAIL rnd_strobe[%0d] got=%h required=%h", idx,
                             {pixel_out, row, col, mem_addr}, exp_strobe(idx));
                else n_pass++;
                idx++; avail = cyc + 3; last_s = cyc;
            end
            if (frame_done) begin
                dones++;
                n_total++;
                if (cyc - last_s !== 1 || idx !== NPIX)
                    $display("FAIL rnd_done_timing got=%0d/%0d required=1/%0d", cyc - last_s, idx, NPIX);
                else n_pass++;
            end else if (dones > 0) break;
        end
        n_total++;
        if (idx !== NPIX || dones !== 1)
            $display("FAIL rnd_count strobes/dones got=%0d/%0d required=%0d/1", idx, dones, NPIX);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int idx = 0, dones = 0, last_s = 0, cyc;
        fill_random();
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (cyc = 1; cyc < LIMIT; cyc++) begin
            @(negedge clk);
            start = (idx == 50 && cyc == last_s + 3) || (idx == 60 && cyc == last_s + 1); #1;
            if (shift_en) begin
                n_total++;
                if ({pixel_out, row, col, mem_addr} !== exp_strobe(idx))
                    $display("FAIL si_strobe[%0d] got=%h required=%h", idx,
                             {pixel_out, row, col, mem_addr}, exp_strobe(idx));
                else n_pass++;
                n_total++;
                if (cyc - last_s !== 3)
                    $display("FAIL si_spacing[%0d] got=%0d required=3", idx, cyc - last_s);
                else n_pass++;
                last_s = cyc; idx++;
            end
            if (frame_done) dones++;
            else if (dones > 0) break;
        end
        start = 1'b0;
        n_total++;
        if (idx !== NPIX || dones !== 1)
            $display("FAIL si_count strobes/dones got=%0d/%0d required=%0d/1", idx, dones, NPIX);
        else n_pass++;
    endtask

    task automatic test_abort();
        int idx = 0, last_s = 0, ab_cyc = -100, cyc;
        bit seen_done = 1'b0, exited = 1'b0;
        fill_random();
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (cyc = 1; cyc < LIMIT; cyc++) begin
            @(negedge clk); start = 1'b0; abort = (idx == 100 && cyc == last_s + 1); #1;
            if (frame_done) seen_done = 1'b1;
            if (abort) begin
                ab_cyc = cyc;
                n_total++;
                if ({shift_en, mem_ren, frame_done} !== 3'b000)
                    $display("FAIL abort_cycle se/ren/done got=%b required=000", {shift_en, mem_ren, frame_done});
                else n_pass++;
            end else if (cyc == ab_cyc + 1) begin
                n_total++;
                if ({busy, mem_ren, frame_done} !== 3'b000)
                    $display("FAIL abort_next busy/ren/done got=%b required=000", {busy, mem_ren, frame_done});
                else n_pass++;
                exited = 1'b1;
                break;
            end
            if (shift_en) begin
                if (idx == 99) begin
                    n_total++;
                    if ({pixel_out, row, col, mem_addr} !== exp_strobe(idx))
                        $display("FAIL abort_strobe99 got=%h required=%h",
                                 {pixel_out, row, col, mem_addr}, exp_strobe(idx));
                    else n_pass++;
                end
                last_s = cyc; idx++;
            end
        end
        abort = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (frame_done) seen_done = 1'b1;
        end
        n_total++;
        if (!exited || seen_done || busy !== 1'b0)
            $display("FAIL abort_quiet exited/done/busy got=%b%b%b required=100", exited, seen_done, busy);
        else n_pass++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        n_total++;
        if ({busy, mem_ren, mem_addr, row, col} !== {2'b11, 20'd0})
            $display("FAIL abort_restart busy/ren/addr/row/col got=%h required=%h",
                     {busy, mem_ren, mem_addr, row, col}, {2'b11, 20'd0});
        else n_pass++;
        @(negedge clk);
        @(negedge clk); abort = 1'b1; #1;
        n_total++;
        if ({shift_en, pixel_out} !== {1'b0, mem[0]})
            $display("FAIL abort_in_present se/pix got=%h required=%h", {shift_en, pixel_out}, {1'b0, mem[0]});
        else n_pass++;
        @(negedge clk); abort = 1'b0; #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_present_exit busy got=%b required=0", busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int idx = 0, s = -100, cyc, bad = 0;
        fill_random();
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (cyc = 1; cyc < LIMIT; cyc++) begin
            @(negedge clk); start = 1'b0; #1;
            if (shift_en) begin
                if (idx == 30) s = cyc;
                idx++;
            end
            if (cyc == s + 2) break;
        end
        n_total++;
        if ({mem_addr, col, busy} !== {10'd31, 5'd3, 1'b1})
            $display("FAIL arst_pre addr/col/busy got=%h required=%h", {mem_addr, col, busy}, {10'd31, 5'd3, 1'b1});
        else n_pass++;
        n_rst = 1'b0; #1;
        n_total++;
        if ({mem_ren, shift_en, busy, frame_done, pixel_out, row, col, mem_addr} !== '0)
            $display("FAIL arst_values got=%h required=0",
                     {mem_ren, shift_en, busy, frame_done, pixel_out, row, col, mem_addr});
        else n_pass++;
        @(negedge clk); n_rst = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if ({busy, mem_ren, shift_en, frame_done} !== 4'b0000) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL arst_stays_idle active_cycles got=%0d required=0", bad);
        else n_pass++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        n_total++;
        if ({mem_ren, mem_addr} !== {1'b1, 10'd0})
            $display("FAIL arst_restart ren/addr got=%h required=%h", {mem_ren, mem_addr}, {1'b1, 10'd0});
        else n_pass++;
        @(negedge clk);
        @(negedge clk); #1;
        n_total++;
        if ({shift_en, pixel_out} !== {1'b1, mem[0]})
            $display("FAIL arst_first_pixel se/pix got=%h required=%h", {shift_en, pixel_out}, {1'b1, mem[0]});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
